// File: rtl/dm_pkg.sv
// dm_pkg -- shared types and helpers for the parametrised data memory.
//   dm_state_t    : controller state (INIT = power-on clear sweep, RUN = serving requests)
//   DM_MAX_RD_LAT : deepest supported read pipeline
//   dm_lanes()    : number of byte lanes in a word of the given width
package dm_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dm_state_t;

    localparam int DM_MAX_RD_LAT = 3;

    function automatic int dm_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dm_rd_pipe.sv
// dm_rd_pipe -- read-response delay line for dm_param.
// Carries {valid, err, data} through RD_LAT register stages so a read
// accepted on edge N is presented on the outputs after edge N+RD_LAT-1,
// i.e. RD_LAT cycles after acceptance. err/data of a stage only load when
// the incoming valid is set, so the outputs hold their last response
// between pulses.
// Ports:
//   clk     : clock
//   rst     : asynchronous active-low reset, flushes every stage
//   i_valid : an accepted read enters the pipe this edge
//   i_err   : that read was out of range
//   i_data  : word read from the array (zero when out of range)
//   o_valid : one-cycle response strobe
//   o_err   : response error flag (held while o_valid=0)
//   o_data  : response data (held while o_valid=0)
module dm_rd_pipe
    import dm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_data
);

    // Out-of-range latencies are pulled into the supported 1..3 window.
    localparam int STAGES = (RD_LAT < 1) ? 1 :
                            (RD_LAT > DM_MAX_RD_LAT) ? DM_MAX_RD_LAT : RD_LAT;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic              r_v;
        logic              r_e;
        logic [DATA_W-1:0] r_d;
        logic              w_in_v;
        logic              w_in_e;
        logic [DATA_W-1:0] w_in_d;

        if (s == 0) begin : g_head
            assign w_in_v = i_valid;
            assign w_in_e = i_err;
            assign w_in_d = i_data;
        end else begin : g_tail
            assign w_in_v = g_stage[s-1].r_v;
            assign w_in_e = g_stage[s-1].r_e;
            assign w_in_d = g_stage[s-1].r_d;
        end

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value, giving a true shift.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_v <= 1'b0;
                r_e <= 1'b0;
                r_d <= '0;
            end else begin
                r_v <= w_in_v;
                if (w_in_v) begin
                    r_e <= w_in_e;
                    r_d <= w_in_d;
                end
            end
        end
    end

    assign o_valid = g_stage[STAGES-1].r_v;
    assign o_err   = g_stage[STAGES-1].r_e;
    assign o_data  = g_stage[STAGES-1].r_d;

endmodule

// File: rtl/dm_param.sv
// dm_param -- parametrised single-port data memory between the CPU
// load/store unit and on-chip RAM.
// Valid/ready request port (never back-pressures once running), per-byte
// write enables, RD_LAT-cycle registered read response, range checking and
// an optional power-on clear sweep.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : request accepted this cycle if req_valid is high
//   req_we     : 1 = write, 0 = read
//   req_be     : byte-lane write enables
//   req_addr   : word address
//   req_wdata  : write data
//   rsp_valid  : one-cycle pulse per accepted read
//   rsp_rdata  : read data (0 for out-of-range reads)
//   rsp_err    : read address was out of range
//   init_busy  : clear sweep in progress
module dm_param
    import dm_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 9,
    parameter int DEPTH      = 512,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [dm_lanes(DATA_W)-1:0] req_be,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        init_busy
);

    localparam int LANES = dm_lanes(DATA_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];

    dm_state_t         r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic              r_ready;
    logic              r_busy;

    logic              w_accept;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_wr_word;

    // Compare with one extra bit so DEPTH == 2**ADDR_W is representable.
    assign w_in_range = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
    assign w_idx      = req_addr[IDX_W-1:0];
    assign w_accept   = req_valid && r_ready;
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    // Byte merge: enabled lanes take new data, the rest keep the stored word.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_mask[8*l +: 8] = {8{req_be[l]}};
    end
    assign w_wr_word = (w_rd_word & ~w_mask) | (req_wdata & w_mask);

    // NOTE: the array has no reset branch; clearing is done by the INIT sweep,
    // which keeps it mappable onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_ptr] <= '0;
        end else if (w_accept && req_we && w_in_range) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= (INIT_CLEAR != 0) ? INIT : RUN;
            r_ptr   <= '0;
            r_ready <= 1'b0;
            r_busy  <= (INIT_CLEAR != 0);
        end else begin
            case (r_state)
                INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == IDX_W'(DEPTH - 1)) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign init_busy = r_busy;

    dm_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept && !req_we),
        .i_err   (!w_in_range),
        .i_data  (w_rd_word),
        .o_valid (rsp_valid),
        .o_err   (rsp_err),
        .o_data  (rsp_rdata)
    );

endmodule

// File: tb/tb_dm_param.sv
// tb_dm_param -- directed bench for dm_param.
// Three instances share one stimulus stream:
//   dut_a : DEPTH=512, RD_LAT=2, INIT_CLEAR=1 (main configuration)
//   dut_b : DEPTH=300, RD_LAT=2, INIT_CLEAR=1 (range checking)
//   dut_c : DEPTH=512, RD_LAT=1, INIT_CLEAR=0 (no sweep, minimum latency)
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_dm_param;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_be;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_init_busy;
    logic [15:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_init_busy;
    logic [15:0] b_rsp_rdata;
    logic        c_req_ready, c_rsp_valid, c_rsp_err, c_init_busy;
    logic [15:0] c_rsp_rdata;

    int checks   = 0;
    int failures = 0;

    dm_param #(.DATA_W(16), .ADDR_W(9), .DEPTH(512), .RD_LAT(2), .INIT_CLEAR(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .init_busy(a_init_busy)
    );

    dm_param #(.DATA_W(16), .ADDR_W(9), .DEPTH(300), .RD_LAT(2), .INIT_CLEAR(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .init_busy(b_init_busy)
    );

    dm_param #(.DATA_W(16), .ADDR_W(9), .DEPTH(512), .RD_LAT(1), .INIT_CLEAR(0)) dut_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(c_req_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err),
        .init_busy(c_init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs edges after reset release until dut_a raises req_ready (bounded).
    // Expected: a ready after edge 512 with busy seen after edges 1..511,
    // b ready after edge 300, c ready after edge 1, and no stray responses.
    task automatic run_sweep(input string tag);
        int busy_cnt = 0;
        int rdy_at   = 0;
        int b_rdy_at = 0;
        int c_rdy_at = 0;
        int vld_cnt  = 0;
        for (int n = 1; n <= 600 && rdy_at == 0; n++) begin
            step();
            if (a_init_busy === 1'b1) busy_cnt++;
            if (a_rsp_valid !== 1'b0) vld_cnt++;
            if (a_req_ready === 1'b1) rdy_at = n;
            if (b_req_ready === 1'b1 && b_rdy_at == 0) b_rdy_at = n;
            if (c_req_ready === 1'b1 && c_rdy_at == 0) c_rdy_at = n;
        end
        check({tag, "_a_ready_edge"}, rdy_at, 512);
        check({tag, "_a_busy_cycles"}, busy_cnt, 511);
        check({tag, "_b_ready_edge"}, b_rdy_at, 300);
        check({tag, "_c_ready_edge"}, c_rdy_at, 1);
        check({tag, "_a_no_rsp"}, vld_cnt, 0);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) step();

        // Reset state
        check("rst_valid", a_rsp_valid, 0);
        check("rst_rdata", a_rsp_rdata, 0);
        check("rst_err",   a_rsp_err,   0);
        check("rst_ready", a_req_ready, 0);
        check("rst_busy",  a_init_busy, 1);
        check("rst_c_busy", c_init_busy, 0);
        check("rst_c_ready", c_req_ready, 0);

        // 1. Sweep with a read of the last word held pending
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'h1FF;
        run_sweep("init");
        step();                       // edge 513: read accepted
        req_valid = 1'b0;
        check("t1_not_early", a_rsp_valid, 0);
        step();                       // RD_LAT=2 -> response now
        check("t1_valid", a_rsp_valid, 1);
        check("t1_rdata", a_rsp_rdata, 16'h0000);
        check("t1_err",   a_rsp_err,   0);
        step();
        check("t1_pulse", a_rsp_valid, 0);

        // 2. Full write then immediate read
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 2'b11;
        req_addr  = 9'd5;
        req_wdata = 16'hBEEF;
        step();
        req_we = 1'b0;
        step();                       // read accepted
        check("t2_c_valid", c_rsp_valid, 1);
        check("t2_c_rdata", c_rsp_rdata, 16'hBEEF);
        check("t2_a_lat",   a_rsp_valid, 0);
        req_valid = 1'b0;
        step();
        check("t2_valid", a_rsp_valid, 1);
        check("t2_rdata", a_rsp_rdata, 16'hBEEF);

        // 3. Low-lane write, empty-mask write, read back: 0xBE34
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 2'b01;
        req_wdata = 16'h1234;
        step();
        req_be    = 2'b00;
        req_wdata = 16'h0000;
        step();
        req_we = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check("t3_valid", a_rsp_valid, 1);
        check("t3_rdata", a_rsp_rdata, 16'hBE34);
        step();
        check("t3_pulse", a_rsp_valid, 0);
        check("t3_hold",  a_rsp_rdata, 16'hBE34);

        // 4. Back-to-back reads return in order on consecutive cycles
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 2'b11;
        req_addr  = 9'd1; req_wdata = 16'h0011; step();
        req_addr  = 9'd2; req_wdata = 16'h0022; step();
        req_addr  = 9'd3; req_wdata = 16'h0033; step();
        req_we    = 1'b0;
        req_addr  = 9'd1; step();
        req_addr  = 9'd2; step();
        check("t4_v1", a_rsp_valid, 1);
        check("t4_d1", a_rsp_rdata, 16'h0011);
        req_addr  = 9'd3; step();
        check("t4_v2", a_rsp_valid, 1);
        check("t4_d2", a_rsp_rdata, 16'h0022);
        req_valid = 1'b0;
        step();
        check("t4_v3", a_rsp_valid, 1);
        check("t4_d3", a_rsp_rdata, 16'h0033);
        step();
        check("t4_end", a_rsp_valid, 0);

        // 5. Range checking on the DEPTH=300 instance
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 2'b11;
        req_addr  = 9'd400;
        req_wdata = 16'h7777;
        step();
        req_we = 1'b0;
        step();                       // read 400 accepted
        req_addr = 9'd144;
        step();                       // read 144 accepted, 400 responds
        check("t5_b_valid", b_rsp_valid, 1);
        check("t5_b_err",   b_rsp_err,   1);
        check("t5_b_rdata", b_rsp_rdata, 16'h0000);
        check("t5_a_rdata", a_rsp_rdata, 16'h7777);
        check("t5_a_err",   a_rsp_err,   0);
        req_valid = 1'b0;
        step();
        check("t5_b_valid2", b_rsp_valid, 1);
        check("t5_b_err2",   b_rsp_err,   0);
        check("t5_b_rdata2", b_rsp_rdata, 16'h0000);

        // 6a. Reset one cycle after a read accept drops the response
        req_valid = 1'b1;
        req_addr  = 9'd5;
        step();
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        check("t6_valid", a_rsp_valid, 0);
        check("t6_rdata", a_rsp_rdata, 0);
        check("t6_err",   a_rsp_err,   0);
        check("t6_ready", a_req_ready, 0);
        check("t6_busy",  a_init_busy, 1);
        step();
        check("t6_dropped", a_rsp_valid, 0);
        rst = 1'b1;
        run_sweep("rst_rd");

        // 6b. Reset at sweep cycle 100 restarts the full sweep
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (100) step();
        rst = 1'b0;
        #1;
        check("t6b_busy",  a_init_busy, 1);
        check("t6b_ready", a_req_ready, 0);
        step();
        rst = 1'b1;
        run_sweep("rst_mid");

        // Word 5 held 0xBE34 before; the sweep must have cleared it
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'd5;
        step();
        req_valid = 1'b0;
        step();
        check("clr_valid", a_rsp_valid, 1);
        check("clr_rdata", a_rsp_rdata, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_param.md
Name: dm_param

Overview:
Parametrised data memory, the next generation of the team's 512x16 data memory. Adds a valid/ready request port, per-byte write enables, a configurable registered read latency, range checking, and a power-on clear sweep. Sits between the CPU load/store unit and on-chip RAM. Single clock domain.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8.
ADDR_W, 9, address width in bits.
DEPTH, 512, number of words; 1 <= DEPTH <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles from request acceptance to rsp_valid; legal values 1..3.
INIT_CLEAR, 1, 1 = zero all words after reset; 0 = skip the sweep.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = write, 0 = read.
req_be  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
req_addr  in  ADDR_W  word address.
req_wdata  in  DATA_W  signed write data.
rsp_valid  out  1  read data valid; one-cycle pulse per accepted read.
rsp_rdata  out  DATA_W  signed read data.
rsp_err  out  1  qualifies rsp_valid; 1 = read address out of range.
init_busy  out  1  clear sweep in progress.

Behaviour:
- Reset, while rst=0:
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
  - init_busy=INIT_CLEAR.
  - Read pipeline flushed; sweep pointer=0; FSM=INIT if INIT_CLEAR=1, else RUN.
  - RAM contents are not reset directly.
- FSM states: INIT, RUN.
  - INIT: writes 0 to word[ptr] each cycle and increments ptr. After writing DEPTH-1, the next edge moves to RUN and clears init_busy.
  - With INIT_CLEAR=1, the sweep takes exactly DEPTH cycles after rst deasserts.
  - RUN: req_ready=1 every cycle; the block never back-pressures.
  - With INIT_CLEAR=0, req_ready is 1 on the first edge after rst deasserts.
- Acceptance: a request is accepted on an edge where req_valid && req_ready. Throughput is one request per cycle.
- Write:
  - Enabled bytes of word[req_addr] update at the acceptance edge; disabled bytes are preserved.
  - be=0 leaves the word unchanged.
  - Writes produce no response.
- Read:
  - rsp_valid is high for exactly one cycle, RD_LAT cycles after the acceptance edge.
  - rsp_rdata returns the word as it stood after all writes accepted on earlier edges.
  - Read-after-write with no gap returns the new data.
  - Responses come back in request order; back-to-back reads give back-to-back rsp_valid.
  - The response side is always ready; there is no stall.
- Out of range (req_addr >= DEPTH):
  - Write is dropped; no aliasing into valid words.
  - Read returns rsp_rdata=0 with rsp_err=1 at the normal latency.
- rsp_rdata and rsp_err hold their last values while rsp_valid=0.
- Requests presented during INIT are ignored (not accepted).
- Reset asserted mid-operation: in-flight reads are dropped (no rsp_valid), the sweep restarts from address 0, and writes not yet accepted are lost.
- rst deassertion is assumed synchronised externally; the block itself only guarantees asynchronous assertion.

Decomposition:
- Package dm_pkg holds:
  - state enum dm_state_t {INIT, RUN};
  - constant DM_MAX_RD_LAT=3;
  - function dm_lanes(DATA_W) = DATA_W/8.
- One sub-module, dm_rd_pipe:
  - RD_LAT-deep shift register carrying {valid, err, data};
  - cleared asynchronously by rst.
- RAM array, FSM and byte-merge logic live in dm_param.

Test Plan (DATA_W=16, ADDR_W=9, DEPTH=512, RD_LAT=2 unless stated):
1. Release rst, hold req_valid=1 -> init_busy=1 for 512 cycles, req_ready rises cycle 513; read 0x1FF -> rsp_valid 2 cycles after accept, rsp_rdata=0x0000, rsp_err=0.
2. Write addr 5 = 0xBEEF, be=2'b11, then read addr 5 on the next cycle -> rsp_rdata=0xBEEF, 2 cycles after read accept.
3. Write addr 5 = 0x1234 be=2'b01, then write addr 5 = 0x0000 be=2'b00, then read 5 -> 0xBE34.
4. Preload addr 1/2/3 = 0x0011/0x0022/0x0033; reads on three consecutive cycles -> rsp_valid high three consecutive cycles, data 0x0011, 0x0022, 0x0033 in order.
5. DEPTH=300: write addr 400 = 0x7777, read 400 -> rsp_err=1, rsp_rdata=0; read addr 144 -> 0x0000, rsp_err=0.
6. Assert rst at sweep cycle 100, and separately one cycle after a read accept -> rsp_valid stays 0, outputs zero immediately; after release the sweep takes the full 512 cycles again.
